// File: rtl/pipeline_pkg.sv
// Shared parameters and helpers for the elastic pipeline family.
package pipeline_pkg;

  localparam int DEFAULT_WIDTH = 1;
  localparam int DEFAULT_DEPTH = 1;

  // Occupancy counter width: enough to hold 0..depth, never narrower than 1 bit.
  function automatic int count_w(input int depth);
    int w;
    w = $clog2(depth + 1);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/elastic_stage.sv
// One elastic register slice: valid bit plus payload, loading whenever it is
// empty or its current item moves on, so bubbles collapse under a stall.
module elastic_stage
  import pipeline_pkg::*;
#(
  parameter int Width = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [Width-1:0] up_data,
  input  logic             down_ready,
  output logic             up_ready,
  output logic             v,
  output logic [Width-1:0] d
);

  logic             v_q;
  logic             v_d;
  logic [Width-1:0] d_q;
  logic [Width-1:0] d_d;
  logic             advance_s;
  logic             load_s;

  // Handshake and next-state for the slice.
  always_comb begin
    advance_s = v_q & down_ready;
    up_ready  = ~v_q | advance_s;
    load_s    = up_ready & up_valid & ~flush;
    v_d       = v_q;
    d_d       = d_q;
    if (flush) begin
      v_d = 1'b0;
    end else if (up_ready) begin
      v_d = up_valid;
    end else begin
      v_d = v_q;
    end
    if (load_s) begin
      d_d = up_data;
    end else begin
      d_d = d_q;
    end
  end

  // Slice state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= 1'b0;
      d_q <= {Width{1'b0}};
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign v = v_q;
  assign d = d_q;

endmodule

// File: rtl/elastic_pipeline.sv
// Valid/ready pipeline of Depth elastic slices with flush and an occupancy
// count; Depth == 0 degenerates to a wire-through with flush gating.
module elastic_pipeline
  import pipeline_pkg::*;
#(
  parameter int  Width  = DEFAULT_WIDTH,
  parameter int  Depth  = DEFAULT_DEPTH,
  localparam int CountW = count_w(Depth)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [Width-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [Width-1:0]  out_data,
  input  logic              flush,
  output logic [CountW-1:0] count
);

  if (Depth == 0) begin : g_pass
    assign out_valid = in_valid;
    assign out_data  = in_data;
    assign in_ready  = out_ready & ~flush;
    assign count     = {CountW{1'b0}};
  end else begin : g_pipe
    logic [Depth-1:0]  v_s;
    logic [Depth-1:0]  up_ready_s;
    logic [Width-1:0]  d_s [Depth];
    logic              in_xfer_s;
    logic              out_xfer_s;
    logic [CountW-1:0] count_q;
    logic [CountW-1:0] count_d;

    for (genvar i = 0; i < Depth; i++) begin : g_stage
      logic             up_valid_s;
      logic [Width-1:0] up_data_s;
      logic             down_ready_s;

      if (i == 0) begin : g_first
        assign up_valid_s = in_valid;
        assign up_data_s  = in_data;
      end else begin : g_chain
        assign up_valid_s = v_s[i-1];
        assign up_data_s  = d_s[i-1];
      end

      if (i == Depth - 1) begin : g_last
        assign down_ready_s = out_ready;
      end else begin : g_inner
        assign down_ready_s = up_ready_s[i+1];
      end

      elastic_stage #(.Width(Width)) u_stage (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .up_valid   (up_valid_s),
        .up_data    (up_data_s),
        .down_ready (down_ready_s),
        .up_ready   (up_ready_s[i]),
        .v          (v_s[i]),
        .d          (d_s[i])
      );
    end

    assign in_ready   = ~flush & up_ready_s[0];
    assign out_valid  = v_s[Depth-1];
    assign out_data   = d_s[Depth-1];
    assign in_xfer_s  = in_valid & in_ready;
    // An output handshake during flush is discarded, so it must not decrement.
    assign out_xfer_s = v_s[Depth-1] & out_ready & ~flush;

    // Occupancy tracking from the two port handshakes.
    always_comb begin
      count_d = count_q;
      if (flush) begin
        count_d = {CountW{1'b0}};
      end else if (in_xfer_s && !out_xfer_s) begin
        count_d = count_q + CountW'(1'b1);
      end else if (!in_xfer_s && out_xfer_s) begin
        count_d = count_q - CountW'(1'b1);
      end else begin
        count_d = count_q;
      end
    end

    // Occupancy register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        count_q <= {CountW{1'b0}};
      end else begin
        count_q <= count_d;
      end
    end

    assign count = count_q;
  end

endmodule

// File: tb/tb_elastic_pipeline.sv
// Directed self-checking bench: Depth 3, Depth 4 and Depth 0 instances, Width 8.
module tb_elastic_pipeline;

  logic clk;
  logic rst;
  int   vec_cnt;
  int   err_cnt;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
  logic [7:0] a_in_data, a_out_data;
  logic [1:0] a_count;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
  logic [7:0] b_in_data, b_out_data;
  logic [2:0] b_count;

  logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_flush;
  logic [7:0] c_in_data, c_out_data;
  logic [0:0] c_count;

  elastic_pipeline #(.Width(8), .Depth(3)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .flush(a_flush), .count(a_count)
  );

  elastic_pipeline #(.Width(8), .Depth(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .flush(b_flush), .count(b_count)
  );

  elastic_pipeline #(.Width(8), .Depth(0)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .flush(c_flush), .count(c_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    vec_cnt++; if (a_out_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_out_valid got %b want 0", a_out_valid); end
    vec_cnt++; if (a_out_data !== 8'h00) begin err_cnt++; $display("FAIL rst_out_data got %h want 00", a_out_data); end
    vec_cnt++; if (a_count !== 2'd0) begin err_cnt++; $display("FAIL rst_count got %0d want 0", a_count); end
    rst = 1'b0;
    #1;
    vec_cnt++; if (a_in_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_in_ready got %b want 1", a_in_ready); end
    vec_cnt++; if (b_count !== 3'd0) begin err_cnt++; $display("FAIL rst_count_b got %0d want 0", b_count); end
    tick();
  endtask

  task automatic test_streaming();
    logic [7:0] exp_d;
    logic       exp_v;
    a_out_ready = 1'b1;
    for (int s = 1; s <= 13; s++) begin
      if (s <= 10) begin
        a_in_valid = 1'b1;
        a_in_data  = 8'(s);
      end else begin
        a_in_valid = 1'b0;
      end
      #1;
      vec_cnt++; if (a_in_ready !== 1'b1) begin err_cnt++; $display("FAIL stream_in_ready s=%0d got %b want 1", s, a_in_ready); end
      tick();
      exp_v = (s >= 3 && s <= 12);
      exp_d = 8'(s - 2);
      vec_cnt++; if (a_out_valid !== exp_v) begin err_cnt++; $display("FAIL stream_valid s=%0d got %b want %b", s, a_out_valid, exp_v); end
      if (exp_v) begin
        vec_cnt++; if (a_out_data !== exp_d) begin err_cnt++; $display("FAIL stream_data s=%0d got %h want %h", s, a_out_data, exp_d); end
      end
      if (s >= 3 && s <= 10) begin
        vec_cnt++; if (a_count !== 2'd3) begin err_cnt++; $display("FAIL stream_count s=%0d got %0d want 3", s, a_count); end
      end
    end
    a_in_valid = 1'b0;
  endtask

  task automatic test_stall_fill();
    logic exp_r;
    b_out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      b_in_valid = 1'b1;
      b_in_data  = 8'(8'h10 + k);
      #1;
      exp_r = (k < 4);
      vec_cnt++; if (b_in_ready !== exp_r) begin err_cnt++; $display("FAIL stall_in_ready k=%0d got %b want %b", k, b_in_ready, exp_r); end
      tick();
    end
    b_in_valid = 1'b0;
    vec_cnt++; if (b_count !== 3'd4) begin err_cnt++; $display("FAIL stall_count got %0d want 4", b_count); end
    b_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      vec_cnt++; if (b_out_valid !== 1'b1) begin err_cnt++; $display("FAIL drain_valid k=%0d got %b want 1", k, b_out_valid); end
      vec_cnt++; if (b_out_data !== 8'(8'h10 + k)) begin err_cnt++; $display("FAIL drain_data k=%0d got %h want %h", k, b_out_data, 8'(8'h10 + k)); end
      tick();
    end
    vec_cnt++; if (b_out_valid !== 1'b0) begin err_cnt++; $display("FAIL drain_empty got %b want 0", b_out_valid); end
    vec_cnt++; if (b_count !== 3'd0) begin err_cnt++; $display("FAIL drain_count got %0d want 0", b_count); end
  endtask

  task automatic test_bubbles();
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    b_in_data   = 8'h21;
    tick();
    b_in_valid = 1'b0;
    tick();
    tick();
    b_in_valid = 1'b1;
    b_in_data  = 8'h22;
    tick();
    b_in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    vec_cnt++; if (b_count !== 3'd2) begin err_cnt++; $display("FAIL bubble_count got %0d want 2", b_count); end
    vec_cnt++; if (b_out_data !== 8'h21) begin err_cnt++; $display("FAIL bubble_head got %h want 21", b_out_data); end
    vec_cnt++; if (b_in_ready !== 1'b1) begin err_cnt++; $display("FAIL bubble_in_ready got %b want 1", b_in_ready); end
    b_out_ready = 1'b1;
    tick();
    vec_cnt++; if (b_out_valid !== 1'b1) begin err_cnt++; $display("FAIL bubble_second_valid got %b want 1", b_out_valid); end
    vec_cnt++; if (b_out_data !== 8'h22) begin err_cnt++; $display("FAIL bubble_second_data got %h want 22", b_out_data); end
    tick();
    vec_cnt++; if (b_out_valid !== 1'b0) begin err_cnt++; $display("FAIL bubble_empty got %b want 0", b_out_valid); end
  endtask

  task automatic test_flush();
    a_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a_in_valid = 1'b1;
      a_in_data  = 8'(8'h31 + k);
      tick();
    end
    vec_cnt++; if (a_count !== 2'd3) begin err_cnt++; $display("FAIL flush_full_count got %0d want 3", a_count); end
    a_flush    = 1'b1;
    a_in_valid = 1'b1;
    a_in_data  = 8'h99;
    #1;
    vec_cnt++; if (a_in_ready !== 1'b0) begin err_cnt++; $display("FAIL flush_in_ready got %b want 0", a_in_ready); end
    tick();
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    vec_cnt++; if (a_count !== 2'd0) begin err_cnt++; $display("FAIL flush_count got %0d want 0", a_count); end
    vec_cnt++; if (a_out_valid !== 1'b0) begin err_cnt++; $display("FAIL flush_out_valid got %b want 0", a_out_valid); end
    a_out_ready = 1'b1;
    for (int s = 1; s <= 5; s++) begin
      a_in_valid = (s <= 2);
      a_in_data  = 8'(8'h40 + s);
      tick();
      if (s >= 3) begin
        vec_cnt++; if (a_out_valid !== (s <= 4)) begin err_cnt++; $display("FAIL post_flush_valid s=%0d got %b want %b", s, a_out_valid, (s <= 4)); end
      end
      if (s == 3 || s == 4) begin
        vec_cnt++; if (a_out_data !== 8'(8'h40 + s - 2)) begin err_cnt++; $display("FAIL post_flush_data s=%0d got %h want %h", s, a_out_data, 8'(8'h40 + s - 2)); end
      end
    end
    a_in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    a_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a_in_valid = 1'b1;
      a_in_data  = 8'(8'h51 + k);
      tick();
    end
    vec_cnt++; if (a_out_valid !== 1'b1) begin err_cnt++; $display("FAIL pre_reset_valid got %b want 1", a_out_valid); end
    #2;
    rst = 1'b1;
    #1;
    vec_cnt++; if (a_out_valid !== 1'b0) begin err_cnt++; $display("FAIL async_rst_valid got %b want 0", a_out_valid); end
    vec_cnt++; if (a_count !== 2'd0) begin err_cnt++; $display("FAIL async_rst_count got %0d want 0", a_count); end
    vec_cnt++; if (a_out_data !== 8'h00) begin err_cnt++; $display("FAIL async_rst_data got %h want 00", a_out_data); end
    a_in_valid = 1'b0;
    tick();
    rst = 1'b0;
    a_in_valid = 1'b1;
    a_in_data  = 8'h61;
    tick();
    a_in_valid = 1'b0;
    vec_cnt++; if (a_out_valid !== 1'b0) begin err_cnt++; $display("FAIL resume_early_valid got %b want 0", a_out_valid); end
    tick();
    vec_cnt++; if (a_out_valid !== 1'b0) begin err_cnt++; $display("FAIL resume_early_valid2 got %b want 0", a_out_valid); end
    tick();
    vec_cnt++; if (a_out_valid !== 1'b1) begin err_cnt++; $display("FAIL resume_valid got %b want 1", a_out_valid); end
    vec_cnt++; if (a_out_data !== 8'h61) begin err_cnt++; $display("FAIL resume_data got %h want 61", a_out_data); end
  endtask

  task automatic test_passthrough();
    c_in_valid  = 1'b1;
    c_in_data   = 8'hA5;
    c_out_ready = 1'b1;
    #1;
    vec_cnt++; if (c_out_data !== 8'hA5) begin err_cnt++; $display("FAIL pass_data got %h want a5", c_out_data); end
    vec_cnt++; if (c_out_valid !== 1'b1) begin err_cnt++; $display("FAIL pass_valid got %b want 1", c_out_valid); end
    vec_cnt++; if (c_in_ready !== 1'b1) begin err_cnt++; $display("FAIL pass_ready_hi got %b want 1", c_in_ready); end
    vec_cnt++; if (c_count !== 1'b0) begin err_cnt++; $display("FAIL pass_count got %0d want 0", c_count); end
    c_out_ready = 1'b0;
    c_in_data   = 8'h3C;
    #1;
    vec_cnt++; if (c_in_ready !== 1'b0) begin err_cnt++; $display("FAIL pass_ready_lo got %b want 0", c_in_ready); end
    vec_cnt++; if (c_out_data !== 8'h3C) begin err_cnt++; $display("FAIL pass_data2 got %h want 3c", c_out_data); end
    c_out_ready = 1'b1;
    c_flush     = 1'b1;
    #1;
    vec_cnt++; if (c_in_ready !== 1'b0) begin err_cnt++; $display("FAIL pass_flush_ready got %b want 0", c_in_ready); end
    c_flush    = 1'b0;
    c_in_valid = 1'b0;
    #1;
    vec_cnt++; if (c_out_valid !== 1'b0) begin err_cnt++; $display("FAIL pass_valid_lo got %b want 0", c_out_valid); end
    tick();
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = 8'h00; a_out_ready = 1'b0; a_flush = 1'b0;
    b_in_valid = 1'b0; b_in_data = 8'h00; b_out_ready = 1'b0; b_flush = 1'b0;
    c_in_valid = 1'b0; c_in_data = 8'h00; c_out_ready = 1'b0; c_flush = 1'b0;
    test_reset();
    test_streaming();
    test_stall_fill();
    test_bubbles();
    test_flush();
    test_reset_mid();
    test_passthrough();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
